// File: rtl/ssp_arbiter.sv
// Round-robin arbiter sharing one SSP APB-style write port among N_REQ byte requesters,
// with burst locks, TX-full throttling and forced RX FIFO drains.
module ssp_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic               PCLK,
   input  logic               CLEAR,
   input  logic [N_REQ-1:0]   REQ,
   input  logic [8*N_REQ-1:0] REQ_DATA,
   input  logic [N_REQ-1:0]   REQ_LAST,
   output logic [N_REQ-1:0]   ACK,
   input  logic               RD_REQ,
   output logic [7:0]         RD_DATA,
   output logic               RD_VALID,
   output logic               LOCKED,
   output logic [2:0]         OWNER,
   output logic               PSEL,
   output logic               PWRITE,
   output logic [7:0]         PWDATA,
   input  logic [7:0]         PRDATA,
   input  logic               SSPTXINTR,
   input  logic               SSPRXINTR
);

   // Handshake: REQ[i] with REQ_DATA/REQ_LAST held stable until the clock edge that
   // ends the cycle in which ACK[i] is high; that edge is the transfer.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

   state_t             state;
   logic [2:0]         grant_q;
   logic               last_q;

   logic [2:0]         start_c;
   logic [N_REQ-1:0]   rot_c;
   logic [2:0]         offs_c;
   logic [3:0]         sum_c;
   logic [2:0]         grant_c;
   logic               found_c;
   logic [N_REQ-1:0]   ack_c;
   logic [7:0]         wdata_c;
   logic               last_c;

   // Rotate the request vector so bit 0 is the index after the last grant.
   always_comb begin
      start_c = (OWNER == LAST_IDX) ? 3'd0 : OWNER + 3'd1;
      rot_c   = N_REQ'({REQ, REQ} >> start_c);
      offs_c  = 3'd0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot_c[j]) begin
            offs_c = 3'(j);
         end
      end
      sum_c = {1'b0, start_c} + {1'b0, offs_c};
      if (sum_c >= 4'(N_REQ)) begin
         sum_c = sum_c - 4'(N_REQ);
      end
   end

   always_comb begin
      grant_c = LOCKED ? OWNER : sum_c[2:0];
      found_c = 1'b0;
      if (LOCKED) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (REQ[i] && (OWNER == 3'(i))) begin
               found_c = 1'b1;
            end
         end
      end else begin
         found_c = |rot_c;
      end
   end

   always_comb begin
      ack_c   = '0;
      wdata_c = 8'd0;
      last_c  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_c == 3'(i)) begin
            ack_c[i] = 1'b1;
            wdata_c  = REQ_DATA[8*i +: 8];
            last_c   = REQ_LAST[i];
         end
      end
   end

   always_ff @(posedge PCLK or posedge CLEAR) begin
      if (CLEAR) begin
         state    <= IDLE;
         grant_q  <= LAST_IDX;
         last_q   <= 1'b0;
         PSEL     <= 1'b0;
         PWRITE   <= 1'b0;
         PWDATA   <= 8'd0;
         ACK      <= '0;
         RD_DATA  <= 8'd0;
         RD_VALID <= 1'b0;
         LOCKED   <= 1'b0;
         OWNER    <= LAST_IDX;
      end else begin
         RD_VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (SSPRXINTR) begin
                  state  <= RD;
                  PSEL   <= 1'b1;
                  PWRITE <= 1'b0;
               end else if (!SSPTXINTR && found_c) begin
                  state   <= WR;
                  PSEL    <= 1'b1;
                  PWRITE  <= 1'b1;
                  PWDATA  <= wdata_c;
                  ACK     <= ack_c;
                  grant_q <= grant_c;
                  last_q  <= last_c;
               end else if (RD_REQ) begin
                  state  <= RD;
                  PSEL   <= 1'b1;
                  PWRITE <= 1'b0;
               end
            end
            WR: begin
               // Always return through IDLE so the SSP flags settle before deciding again.
               state  <= IDLE;
               PSEL   <= 1'b0;
               PWRITE <= 1'b0;
               ACK    <= '0;
               OWNER  <= grant_q;
               LOCKED <= ~last_q;
            end
            RD: begin
               state    <= IDLE;
               PSEL     <= 1'b0;
               PWRITE   <= 1'b0;
               RD_DATA  <= PRDATA;
               RD_VALID <= 1'b1;
            end
            default: begin
               state <= IDLE;
               PSEL  <= 1'b0;
               ACK   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ssp_arbiter.sv
// Bench for ssp_arbiter: reset check, a table of directed vectors, hand-written corner
// sequences and randomized traffic against a transaction-level reference model.
module tb_ssp_arbiter;

   localparam int N = 4;

   logic           PCLK;
   logic           CLEAR;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   ACK;
   logic           rd_req;
   logic [7:0]     RD_DATA;
   logic           RD_VALID;
   logic           LOCKED;
   logic [2:0]     OWNER;
   logic           PSEL;
   logic           PWRITE;
   logic [7:0]     PWDATA;
   logic [7:0]     prdata;
   logic           txintr;
   logic           rxintr;

   ssp_arbiter #(.N_REQ(N)) dut (
      .PCLK      (PCLK),
      .CLEAR     (CLEAR),
      .REQ       (req),
      .REQ_DATA  (req_data),
      .REQ_LAST  (req_last),
      .ACK       (ACK),
      .RD_REQ    (rd_req),
      .RD_DATA   (RD_DATA),
      .RD_VALID  (RD_VALID),
      .LOCKED    (LOCKED),
      .OWNER     (OWNER),
      .PSEL      (PSEL),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (prdata),
      .SSPTXINTR (txintr),
      .SSPRXINTR (rxintr)
   );

   // clock / reset
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int vectors;
   int miscompares;

   // reference model state
   logic         exp_psel, exp_pwrite, exp_rd_valid, exp_locked;
   logic [7:0]   exp_pwdata, exp_rd_data;
   logic [N-1:0] exp_ack;
   int           exp_owner;
   bit           m_busy;
   int           m_g;
   logic         m_last;
   logic [N-1:0] done_ack;

   // requester byte queues {last, data}
   logic [8:0]   fq[N][64];
   int           hd[N];
   int           tl[N];

   logic [7:0]   exp_q[$];
   logic [7:0]   obs_q[$];

   typedef struct {
      logic [N-1:0]   req;
      logic [8*N-1:0] data;
      logic [N-1:0]   last;
      logic           tx;
      logic           psel;
      logic           pwrite;
      logic [7:0]     pwdata;
      logic [N-1:0]   ack;
      logic           locked;
      logic [2:0]     owner;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
      end
   endtask

   // Winner is the requester closest after the last grant, going round the ring.
   function automatic int pick_grant(input logic [N-1:0] r, input int own, input logic lk);
      int best;
      int best_dist;
      best = -1;
      best_dist = N;
      if (lk) return r[own] ? own : -1;
      for (int i = 0; i < N; i++) begin
         if (r[i] && ((i - own - 1 + 2*N) % N) < best_dist) begin
            best_dist = (i - own - 1 + 2*N) % N;
            best = i;
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      exp_psel = 1'b0; exp_pwrite = 1'b0; exp_pwdata = 8'd0; exp_ack = '0;
      exp_rd_data = 8'd0; exp_rd_valid = 1'b0; exp_locked = 1'b0; exp_owner = N - 1;
      m_busy = 1'b0; m_g = 0; m_last = 1'b0;
   endtask

   task automatic model_edge();
      int g;
      if (m_busy) begin
         m_busy = 1'b0;
         if (exp_pwrite) begin
            exp_owner = m_g;
            exp_locked = !m_last;
            exp_rd_valid = 1'b0;
         end else begin
            exp_rd_data = prdata;
            exp_rd_valid = 1'b1;
         end
         exp_psel = 1'b0; exp_pwrite = 1'b0; exp_ack = '0;
      end else begin
         exp_rd_valid = 1'b0;
         g = pick_grant(req, exp_owner, exp_locked);
         if (rxintr || (!(!txintr && g >= 0) && rd_req)) begin
            m_busy = 1'b1; exp_psel = 1'b1; exp_pwrite = 1'b0;
         end else if (!txintr && g >= 0) begin
            m_busy = 1'b1; exp_psel = 1'b1; exp_pwrite = 1'b1;
            exp_pwdata = req_data[8*g +: 8];
            exp_ack = '0;
            exp_ack[g] = 1'b1;
            m_g = g;
            m_last = req_last[g];
         end
      end
   endtask

   task automatic compare_all();
      chk("psel", 32'(PSEL), 32'(exp_psel));
      chk("pwrite", 32'(PWRITE), 32'(exp_pwrite));
      chk("ack", 32'(ACK), 32'(exp_ack));
      chk("locked", 32'(LOCKED), 32'(exp_locked));
      chk("owner", 32'(OWNER), 32'(exp_owner));
      chk("rd_valid", 32'(RD_VALID), 32'(exp_rd_valid));
      chk("rd_data", 32'(RD_DATA), 32'(exp_rd_data));
      if (exp_psel && exp_pwrite) chk("pwdata", 32'(PWDATA), 32'(exp_pwdata));
   endtask

   task automatic step();
      done_ack = exp_ack;
      @(posedge PCLK);
      model_edge();
      #1;
      compare_all();
      if (PSEL && PWRITE) obs_q.push_back(PWDATA);
   endtask

   // driver tasks
   task automatic push(input int i, input logic [7:0] d, input logic l);
      fq[i][tl[i] % 64] = {l, d};
      tl[i]++;
   endtask

   task automatic drive_fifos();
      for (int i = 0; i < N; i++) begin
         if (hd[i] != tl[i]) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = fq[i][hd[i] % 64][7:0];
            req_last[i] = fq[i][hd[i] % 64][8];
         end else begin
            req[i] = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      step();
      for (int i = 0; i < N; i++) begin
         if (done_ack[i] && hd[i] != tl[i]) hd[i]++;
      end
      drive_fifos();
   endtask

   task automatic check_order(input string nm);
      chk({nm, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < obs_q.size()) chk(nm, 32'(obs_q[k]), 32'(exp_q[k]));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
      tbl[0]  = '{4'b0001, 32'h00000035, 4'hF, 1'b0, 1'b1, 1'b1, 8'h35, 4'b0001, 1'b0, 3'd3};
      tbl[1]  = '{4'b0001, 32'h00000035, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0};
      tbl[2]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b1, 8'h33, 4'b0010, 1'b0, 3'd0};
      tbl[3]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd1};
      tbl[4]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b1, 8'h22, 4'b0100, 1'b0, 3'd1};
      tbl[5]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd2};
      tbl[6]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b1, 8'h11, 4'b1000, 1'b0, 3'd2};
      tbl[7]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd3};
      tbl[8]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b1, 8'h44, 4'b0001, 1'b0, 3'd3};
      tbl[9]  = '{4'b1111, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0};
      tbl[10] = '{4'b1000, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0};
      tbl[11] = '{4'b1000, 32'h11223344, 4'hF, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0};
      tbl[12] = '{4'b1000, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b1, 8'h11, 4'b1000, 1'b0, 3'd0};
      tbl[13] = '{4'b1000, 32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd3};

      // reset
      CLEAR = 1'b1;
      req = '0; req_data = '0; req_last = '0;
      rd_req = 1'b0; prdata = 8'd0; txintr = 1'b0; rxintr = 1'b0;
      model_reset();
      repeat (2) @(posedge PCLK);
      #1;
      chk("rst_psel", 32'(PSEL), 32'd0);
      chk("rst_pwrite", 32'(PWRITE), 32'd0);
      chk("rst_pwdata", 32'(PWDATA), 32'd0);
      chk("rst_ack", 32'(ACK), 32'd0);
      chk("rst_rd_data", 32'(RD_DATA), 32'd0);
      chk("rst_rd_valid", 32'(RD_VALID), 32'd0);
      chk("rst_locked", 32'(LOCKED), 32'd0);
      chk("rst_owner", 32'(OWNER), 32'(N - 1));
      CLEAR = 1'b0;

      // single write, round robin, TX full
      for (int r = 0; r < 14; r++) begin
         req = tbl[r].req; req_data = tbl[r].data; req_last = tbl[r].last; txintr = tbl[r].tx;
         step();
         chk("tbl_psel", 32'(PSEL), 32'(tbl[r].psel));
         chk("tbl_pwrite", 32'(PWRITE), 32'(tbl[r].pwrite));
         chk("tbl_ack", 32'(ACK), 32'(tbl[r].ack));
         chk("tbl_locked", 32'(LOCKED), 32'(tbl[r].locked));
         chk("tbl_owner", 32'(OWNER), 32'(tbl[r].owner));
         if (tbl[r].psel) chk("tbl_pwdata", 32'(PWDATA), 32'(tbl[r].pwdata));
      end
      obs_q.delete();
      txintr = 1'b0;

      // burst lock on requester 1 while requester 2 waits
      push(1, 8'hAE, 1'b0); push(1, 8'h26, 1'b0); push(1, 8'h39, 1'b1); push(2, 8'h5A, 1'b1);
      exp_q = '{8'hAE, 8'h26, 8'h39, 8'h5A};
      drive_fifos();
      repeat (10) cycle();
      check_order("burst_order");
      chk("burst_end_locked", 32'(LOCKED), 32'd0);
      chk("burst_end_owner", 32'(OWNER), 32'd2);

      // RX full interrupts a locked burst
      push(3, 8'h61, 1'b0); push(3, 8'h62, 1'b0); push(3, 8'h63, 1'b1); push(0, 8'h70, 1'b1);
      exp_q = '{8'h61, 8'h62, 8'h63, 8'h70};
      drive_fifos();
      cycle();
      rxintr = 1'b1; prdata = 8'h9D;
      cycle();
      cycle();
      chk("rx_psel", 32'(PSEL), 32'd1);
      chk("rx_pwrite", 32'(PWRITE), 32'd0);
      rxintr = 1'b0;
      cycle();
      chk("rx_valid", 32'(RD_VALID), 32'd1);
      chk("rx_data", 32'(RD_DATA), 32'h9D);
      chk("rx_locked", 32'(LOCKED), 32'd1);
      chk("rx_owner", 32'(OWNER), 32'd3);
      prdata = 8'h00;
      repeat (8) cycle();
      check_order("rx_order");

      // CLEAR pulsed during a write
      push(2, 8'h44, 1'b0); push(2, 8'h45, 1'b1); push(0, 8'h55, 1'b1);
      drive_fifos();
      cycle();
      chk("pre_clr_ack", 32'(ACK), 32'b0100);
      #2 CLEAR = 1'b1;
      #1;
      chk("clr_psel", 32'(PSEL), 32'd0);
      chk("clr_ack", 32'(ACK), 32'd0);
      chk("clr_locked", 32'(LOCKED), 32'd0);
      chk("clr_owner", 32'(OWNER), 32'(N - 1));
      model_reset();
      CLEAR = 1'b0;
      obs_q.delete();
      exp_q = '{8'h55, 8'h44, 8'h45};
      repeat (10) cycle();
      check_order("clr_order");

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         cycle();
         for (int i = 0; i < N; i++) begin
            if ((tl[i] - hd[i]) < 3 && $urandom_range(0, 3) == 0)
               push(i, 8'($urandom), ($urandom_range(0, 2) == 0));
         end
         drive_fifos();
         txintr = ($urandom_range(0, 9) < 3);
         rxintr = ($urandom_range(0, 19) == 0);
         rd_req = ($urandom_range(0, 7) == 0);
         prdata = 8'($urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
